// File: rtl/collision_game_ctrl.sv
// Collision detection and round state machine for the flappy-bird raster pipeline.
// Optional build macro GOD_MODE_EN: pipe/floor hits still pulse collision but never end the round.
module collision_game_ctrl #(
    parameter int VISIBLE_WIDTH  = 640,
    parameter int VISIBLE_HEIGHT = 480,
    parameter int FLOOR_Y        = 460,
    parameter int HIT_THRESHOLD  = 4,
    parameter int DEATH_FRAMES   = 30
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [9:0]  hCount,
    input  logic [9:0]  vCount,
    input  logic        pipe_pixel,
    input  logic        bird_pixel,
    input  logic        flap,
    output logic        game_enable,
    output logic        round_reset,
    output logic        collision,
    output logic [2:0]  state,
    output logic [15:0] frames_survived
);

    localparam int DW = $clog2(DEATH_FRAMES + 1);
    localparam logic [9:0]    H_VIS   = 10'(VISIBLE_WIDTH);
    localparam logic [9:0]    V_VIS   = 10'(VISIBLE_HEIGHT);
    localparam logic [9:0]    V_FLOOR = 10'(FLOOR_Y);
    localparam logic [7:0]    HIT_THR = 8'(HIT_THRESHOLD);
    localparam logic [DW-1:0] DEATH_N = DW'(DEATH_FRAMES);

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        PLAYING   = 3'd1,
        HIT       = 3'd2,
        GAME_OVER = 3'd3,
        RESTART   = 3'd4
    } state_t;

    state_t        state_q, state_d;
    logic [7:0]    overlap_q;
    logic          floor_q;
    logic [DW-1:0] death_q, death_d;
    logic [15:0]   frames_q, frames_d;
    logic          flap_prev;
    logic          fe_cmp_q;
    logic          collision_d, game_enable_d, round_reset_d;

    logic vis, fe_cmp, frame_end, flap_rise, hit;

    assign vis       = (hCount < H_VIS) && (vCount < V_VIS);
    assign fe_cmp    = (vCount == V_VIS) && (hCount == 10'd0);
    assign frame_end = fe_cmp && !fe_cmp_q;
    assign flap_rise = flap && !flap_prev;
    assign hit       = (overlap_q >= HIT_THR) || floor_q;

    assign state           = state_q;
    assign frames_survived = frames_q;

    // Scan-side accumulation; fe_cmp_q resets high so a raster parked on the
    // frame-end position across reset release does not fire a spurious frame_end.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            overlap_q <= '0;
            floor_q   <= 1'b0;
            flap_prev <= 1'b0;
            fe_cmp_q  <= 1'b1;
        end else begin
            flap_prev <= flap;
            fe_cmp_q  <= fe_cmp;
            if (frame_end) begin
                overlap_q <= '0;
                floor_q   <= 1'b0;
            end else begin
                if (vis && pipe_pixel && bird_pixel && overlap_q != 8'hFF)
                    overlap_q <= overlap_q + 8'd1;
                if (vis && bird_pixel && vCount >= V_FLOOR)
                    floor_q <= 1'b1;
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= IDLE;
            death_q     <= '0;
            frames_q    <= '0;
            collision   <= 1'b0;
            game_enable <= 1'b0;
            round_reset <= 1'b0;
        end else begin
            state_q     <= state_d;
            death_q     <= death_d;
            frames_q    <= frames_d;
            collision   <= collision_d;
            game_enable <= game_enable_d;
            round_reset <= round_reset_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        death_d     = death_q;
        frames_d    = frames_q;
        collision_d = 1'b0;
        case (state_q)
            IDLE: begin
                if (flap_rise) begin
                    state_d  = PLAYING;
                    frames_d = '0;
                end
            end
            PLAYING: begin
                if (frame_end) begin
                    if (hit) begin
                        collision_d = 1'b1;
`ifdef GOD_MODE_EN
                        if (frames_q != 16'hFFFF)
                            frames_d = frames_q + 16'd1;
`else
                        state_d = HIT;
                        death_d = '0;
`endif
                    end else if (frames_q != 16'hFFFF) begin
                        frames_d = frames_q + 16'd1;
                    end
                end
            end
            HIT: begin
                if (frame_end) begin
                    death_d = death_q + 1'b1;
                    if (death_d == DEATH_N)
                        state_d = GAME_OVER;
                end
            end
            GAME_OVER: begin
                if (flap_rise)
                    state_d = RESTART;
            end
            RESTART: state_d = IDLE;
            default: state_d = IDLE;
        endcase
        game_enable_d = (state_d == PLAYING);
        round_reset_d = (state_d == RESTART);
    end

endmodule
